// File: rtl/run_pattern_gen.sv
// Purpose : serial stimulus generator emitting alternating zero-runs and one-runs on w.
// Latency : outputs are registered; the first pattern cycle appears one cycle after start is accepted.
// Backpressure: none; start is honoured only in IDLE and is dropped (not queued) otherwise.
//
// Ports:
//   clk        rising-edge system clock
//   reset      asynchronous active-low reset
//   start      one-cycle request, accepted only in IDLE
//   zeros_len  zero-run length in cycles (latched on accept)
//   ones_len   one-run length in cycles (latched on accept)
//   reps       number of zero+one periods (latched on accept, 0 behaves as 1)
//   loop       (PATTERN_LOOP_EN only) restart instead of finishing at a final period end
//   w          serial output stream
//   busy       high while emitting zeros or ones
//   done       one-cycle completion pulse
//   rep_cnt    periods completed in the current operation (saturating)
//   state      FSM state: 0 IDLE, 1 ZEROS, 2 ONES, 3 DONE
//
// Build option: define PATTERN_LOOP_EN to add the loop input.

module run_pattern_gen #(
  parameter int CNT_W = 4,
  parameter int REP_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] zeros_len,
  input  logic [CNT_W-1:0] ones_len,
  input  logic [REP_W-1:0] reps,
`ifdef PATTERN_LOOP_EN
  input  logic             loop,
`endif
  output logic             w,
  output logic             busy,
  output logic             done,
  output logic [REP_W-1:0] rep_cnt,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ZEROS = 3'd1,
    ONES  = 3'd2,
    DONE  = 3'd3
  } state_t;

  state_t             r_state, w_nxt_state;
  logic [CNT_W-1:0]   r_zlen, w_nxt_zlen;
  logic [CNT_W-1:0]   r_olen, w_nxt_olen;
  logic [REP_W-1:0]   r_reps, w_nxt_reps;
  logic [CNT_W-1:0]   r_run, w_nxt_run;
  logic [REP_W-1:0]   r_rep, w_nxt_rep;
  logic               r_w, r_busy, r_done;

  logic               w_period_end;
  logic               w_loop;
  logic [REP_W:0]     w_rep_p1;
  logic               w_more_reps;
  logic [REP_W-1:0]   w_rep_inc;

`ifdef PATTERN_LOOP_EN
  assign w_loop = loop;
`else
  assign w_loop = 1'b0;
`endif

  // Compare one bit wider so rep_cnt+1 never wraps before the comparison.
  assign w_rep_p1    = {1'b0, r_rep} + {{REP_W{1'b0}}, 1'b1};
  assign w_more_reps = (w_rep_p1 < {1'b0, r_reps});
  assign w_rep_inc   = (&r_rep) ? r_rep : w_rep_p1[REP_W-1:0];

  always_comb begin
    w_nxt_state  = r_state;
    w_nxt_zlen   = r_zlen;
    w_nxt_olen   = r_olen;
    w_nxt_reps   = r_reps;
    w_nxt_run    = r_run;
    w_nxt_rep    = r_rep;
    w_period_end = 1'b0;

    case (r_state)
      IDLE: begin
        if (start) begin
          w_nxt_zlen = zeros_len;
          w_nxt_olen = ones_len;
          w_nxt_reps = (reps == '0) ? REP_W'(1) : reps;
          w_nxt_rep  = '0;
          if (zeros_len != '0) begin
            w_nxt_state = ZEROS;
            w_nxt_run   = zeros_len;
          end else if (ones_len != '0) begin
            w_nxt_state = ONES;
            w_nxt_run   = ones_len;
          end else begin
            w_nxt_state = DONE;
          end
        end
      end
      ZEROS: begin
        // Run counter holds the cycles remaining including the current one.
        if (r_run > CNT_W'(1)) begin
          w_nxt_run = r_run - CNT_W'(1);
        end else if (r_olen != '0) begin
          w_nxt_state = ONES;
          w_nxt_run   = r_olen;
        end else begin
          w_period_end = 1'b1;
        end
      end
      ONES: begin
        if (r_run > CNT_W'(1)) begin
          w_nxt_run = r_run - CNT_W'(1);
        end else begin
          w_period_end = 1'b1;
        end
      end
      DONE:    w_nxt_state = IDLE;
      default: w_nxt_state = IDLE;
    endcase

    // A period end can only be reached with at least one nonzero length,
    // so restarting always lands in a phase that emits something.
    if (w_period_end) begin
      if (w_more_reps || w_loop) begin
        w_nxt_rep = w_more_reps ? w_rep_inc : '0;
        if (r_zlen != '0) begin
          w_nxt_state = ZEROS;
          w_nxt_run   = r_zlen;
        end else begin
          w_nxt_state = ONES;
          w_nxt_run   = r_olen;
        end
      end else begin
        w_nxt_rep   = w_rep_inc;
        w_nxt_state = DONE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_zlen  <= '0;
      r_olen  <= '0;
      r_reps  <= '0;
      r_run   <= '0;
      r_rep   <= '0;
      r_w     <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_zlen  <= w_nxt_zlen;
      r_olen  <= w_nxt_olen;
      r_reps  <= w_nxt_reps;
      r_run   <= w_nxt_run;
      r_rep   <= w_nxt_rep;
      // Output flops are loaded from the next-state decode so they switch
      // cleanly alongside the state register.
      r_w     <= (w_nxt_state == ONES);
      r_busy  <= (w_nxt_state == ZEROS) || (w_nxt_state == ONES);
      r_done  <= (w_nxt_state == DONE);
    end
  end

  assign w       = r_w;
  assign busy    = r_busy;
  assign done    = r_done;
  assign rep_cnt = r_rep;
  assign state   = r_state;

endmodule

// File: doc/run_pattern_gen.md
Name: run_pattern_gen

Overview:
- Serial stimulus generator: emits a programmable single-bit stream of alternating zero-runs and one-runs on `w`.
- Output is the transmit-side counterpart of the team's run-length/consecutive-ones counter; `w` connects directly to that counter's `input1`.
- Used in on-chip self-test and in benches in place of hand-written per-edge stimulus.
- Start is a one-cycle request; status is reported via `busy`, a `done` pulse, and the FSM state.

Parameters:
- CNT_W, 4: width of the run-length inputs and internal run counters.
- REP_W, 3: width of the repetition-count input and `rep_cnt` output.

Ports:
- clk  input  1  system clock; all logic rising-edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- start  input  1  request; accepted only in IDLE.
- zeros_len  input  CNT_W  zero-run length in cycles, latched on accept.
- ones_len  input  CNT_W  one-run length in cycles, latched on accept.
- reps  input  REP_W  number of zero+one periods, latched on accept; 0 is treated as 1.
- w  output  1  registered serial stream.
- busy  output  1  high in ZEROS/ONES.
- done  output  1  one-cycle pulse in DONE.
- rep_cnt  output  REP_W  completed periods in the current operation.
- state  output  3  FSM state.

Behaviour:
- Reset (asynchronous, reset=0):
  - state=IDLE(3'd0); w=0, busy=0, done=0, rep_cnt=0.
  - Latched lengths and internal counters are cleared.
  - Takes effect immediately, including mid-run.
  - First transition occurs on the first rising edge after reset returns to 1.
- State encoding: IDLE=0, ZEROS=1, ONES=2, DONE=3; codes 4-7 are illegal and return to IDLE on the next edge.
- IDLE:
  - w=0.
  - start=1 at edge k latches zeros_len, ones_len and reps (0 → 1), and clears rep_cnt.
  - Next state is ZEROS if zeros_len≠0, else ONES if ones_len≠0, else DONE.
- ZEROS: w=0 for exactly zeros_len cycles, the first at cycle k+1; then → ONES, or skip ONES if ones_len=0.
- ONES: w=1 for exactly ones_len cycles.
- End of a period (completion of the ones phase, or of the zeros phase when ones_len=0):
  - rep_cnt increments on the same edge.
  - If rep_cnt+1 < reps: → ZEROS (or ONES if zeros_len=0).
  - Otherwise: → DONE.
- DONE: one cycle only; w=0, busy=0, done=1; → IDLE.
- Both lengths zero: IDLE → DONE → IDLE; rep_cnt stays 0; no 1 is emitted.
- start while not in IDLE (ZEROS, ONES, DONE): ignored, no queuing. Input changes after acceptance have no effect.
- Timing: w, busy, done, state and rep_cnt are all registered, so output latency is 1 cycle from the accepting edge.
- Total length of an operation: (zeros_len+ones_len)·reps cycles, plus 1 DONE cycle.
- Counters: run counters count down from the latched length to 1; there is no wrap. rep_cnt saturates at 2^REP_W−1.

Optional Feature:
- Macro: PATTERN_LOOP_EN
- Defined:
  - Adds input port `loop` (1 bit), sampled at each period end.
  - If loop=1 at the point where the FSM would enter DONE: rep_cnt clears and the FSM re-enters the first nonzero phase. No DONE cycle and no gap occur.
  - loop=0 at a period end completes normally.
  - A both-zero configuration ignores loop and goes to DONE.
- Not defined: the `loop` port is absent and behaviour is exactly as above.

Test Plan:
- Reset mid-run: zeros_len=2, ones_len=5, reps=1, start; assert reset=0 during the 3rd one-cycle → state=0, w=0, busy=0 immediately (before the next edge); release; no output until a new start.
- Basic run: zeros_len=1, ones_len=7, reps=1, start at edge k:
  - w=0 at cycle k+1, w=1 at cycles k+2..k+8.
  - done=1 at k+9 only; busy high k+1..k+8.
  - The attached counter sees 7 consecutive ones.
- Repetition and ignored start: zeros_len=2, ones_len=3, reps=2 → w=0,0,1,1,1,0,0,1,1,1; rep_cnt 0→1→2; done 1 cycle after the final 1. start pulsed mid-run → no effect.
- Degenerate lengths:
  - zeros_len=0, ones_len=4, reps=3 → w=1 for 12 contiguous cycles.
  - zeros_len=0, ones_len=0 → state 0→3→0, w stays 0.
- reps=0 with zeros_len=1, ones_len=1 → behaves as reps=1: w=0,1, then done.
- PATTERN_LOOP_EN, loop=1: zeros_len=1, ones_len=2 → pattern 0,1,1 repeats with no DONE. Drop loop → the current period finishes, done pulses, then IDLE.
